// File: rtl/fht_result_reader_if.sv
// ---------------------------------------------------------------------------
// fht_result_reader_if
//
// Purpose: valid/ready result stream between fht_result_reader and its
//          downstream consumer (UART, DMA, analysis logic).
//
// Signals:
//   oDATA   reader -> consumer  D_BIT    signed spectrum value
//   oINDEX  reader -> consumer  A_BIT+2  spectrum index of oDATA
//   oVALID  reader -> consumer  1        stream valid
//   oLAST   reader -> consumer  1        high with index N-1
//   iREADY  consumer -> reader  1        consumer ready
//
// Modports: master = reader side, slave = consumer side.
// ---------------------------------------------------------------------------
interface fht_result_reader_if #(
    parameter int D_BIT = 16,
    parameter int A_BIT = 8
);
    logic signed [D_BIT-1:0] oDATA;
    logic        [A_BIT+1:0] oINDEX;
    logic                    oVALID;
    logic                    oLAST;
    logic                    iREADY;

    modport master (output oDATA, output oINDEX, output oVALID, output oLAST,
                    input  iREADY);
    modport slave  (input  oDATA, input  oINDEX, input  oVALID, input  oLAST,
                    output iREADY);
endinterface

// File: rtl/fht_result_reader.sv
// ---------------------------------------------------------------------------
// fht_result_reader
//
// Purpose: unloads a finished FHT frame from the four result RAM banks of
//          fht_top and streams the N points in natural index order.
//          A rising edge of iRDY starts a read-out; one shared address is
//          driven to all banks, the bank select is delayed by the RAM read
//          latency, and a small FIFO absorbs that latency so the stream can
//          stall without losing samples.
//
// Ports:
//   iCLK, iRESET         clock, synchronous active-low reset
//   iRDY                 fht_top oRDY; rise starts, fall mid-frame aborts
//   oADDR_RD_0..3        shared bank read address
//   iDATA_0..3           bank read data, valid RD_LAT clocks after address
//   strm (master)        oDATA / oINDEX / oVALID / oLAST / iREADY stream
//   oBUSY                high in READ or DRAIN
//   oDONE                one-cycle pulse after the last handshake
//   oABORT               one-cycle pulse when a read-out is cancelled
//
// Build option:
//   FHT_RD_BANK_BITREV_EN  bank select uses the two bank bits swapped, to
//                          undo the bit-reversed bank order used on load.
// ---------------------------------------------------------------------------
module fht_result_reader #(
    parameter int N      = 1024,
    parameter int D_BIT  = 16,
    parameter int A_BIT  = 8,
    parameter int RD_LAT = 2
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic                    iRDY,
    output logic        [A_BIT-1:0] oADDR_RD_0,
    output logic        [A_BIT-1:0] oADDR_RD_1,
    output logic        [A_BIT-1:0] oADDR_RD_2,
    output logic        [A_BIT-1:0] oADDR_RD_3,
    input  logic signed [D_BIT-1:0] iDATA_0,
    input  logic signed [D_BIT-1:0] iDATA_1,
    input  logic signed [D_BIT-1:0] iDATA_2,
    input  logic signed [D_BIT-1:0] iDATA_3,
    output logic                    oBUSY,
    output logic                    oDONE,
    output logic                    oABORT,
    fht_result_reader_if.master     strm
);

    localparam int FIFO_DEPTH = RD_LAT + 2;
    localparam int PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW         = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;
    localparam int IW         = A_BIT + 2;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic signed [D_BIT-1:0] data;
        logic        [IW-1:0]    idx;
    } beat_t;

    state_t           state_q, state_d;
    logic             rdy_q, rdy_d;
    logic [IW-1:0]    cnt_q, cnt_d;
    logic [A_BIT-1:0] addr_q, addr_d;
    logic             abort_q, abort_d;

    // Read pipeline: stage 0 is set when an address is issued, stage RD_LAT
    // is the cycle in which the bank data for that address is on iDATA_x.
    logic [RD_LAT:0]  pipe_vld_q, pipe_vld_d;
    logic [IW-1:0]    pipe_idx_q [RD_LAT+1];
    logic [IW-1:0]    pipe_idx_d [RD_LAT+1];

    beat_t            fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    fifo_cnt_q, fifo_cnt_d;

    logic             rise;
    logic             issue;
    logic             push;
    logic             pop;
    logic [CW-1:0]    in_flight;
    logic [1:0]       cap_bank;
    beat_t            cap_beat;
    beat_t            head;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Bank of the sample whose data is arriving this cycle.
    always_comb begin
`ifdef FHT_RD_BANK_BITREV_EN
        cap_bank = {pipe_idx_q[RD_LAT][A_BIT], pipe_idx_q[RD_LAT][A_BIT+1]};
`else
        cap_bank = pipe_idx_q[RD_LAT][A_BIT+1:A_BIT];
`endif
        cap_beat.idx = pipe_idx_q[RD_LAT];
        case (cap_bank)
            2'd0:    cap_beat.data = iDATA_0;
            2'd1:    cap_beat.data = iDATA_1;
            2'd2:    cap_beat.data = iDATA_2;
            default: cap_beat.data = iDATA_3;
        endcase
    end

    assign head = fifo_mem_q[rd_ptr_q];
    assign push = pipe_vld_q[RD_LAT];
    assign pop  = (fifo_cnt_q != '0) && strm.iREADY;
    assign rise = iRDY && !rdy_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        rdy_d      = iRDY;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        abort_d    = 1'b0;
        issue      = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;

        in_flight = '0;
        for (int i = 0; i <= RD_LAT; i++) begin
            in_flight = in_flight + CW'(pipe_vld_q[i]);
        end

        pipe_vld_d = {pipe_vld_q[RD_LAT-1:0], 1'b0};
        pipe_idx_d[0] = pipe_idx_q[0];
        for (int i = 1; i <= RD_LAT; i++) begin
            pipe_idx_d[i] = pipe_idx_q[i-1];
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rise) state_d = S_READ;
            end
            S_READ: begin
                // Every issued address owns a FIFO slot from issue until it
                // is popped; a slot freed by this cycle's pop counts as free,
                // which is what sustains one sample per clock.
                issue = (fifo_cnt_q + in_flight) < (CW'(FIFO_DEPTH) + CW'(pop));
                if (issue) begin
                    addr_d        = cnt_q[A_BIT-1:0];
                    pipe_vld_d[0] = 1'b1;
                    pipe_idx_d[0] = cnt_q;
                    if (cnt_q == LAST_IDX) state_d = S_DRAIN;
                    else                   cnt_d   = cnt_q + IW'(1);
                end
            end
            S_DRAIN: begin
                if (pop && head.idx == LAST_IDX) state_d = S_DONE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        if (push) wr_ptr_d = ptr_next(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_next(rd_ptr_q);
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);

        // A falling iRDY mid-frame means fht_top has started a new frame and
        // overwrites the banks: drop everything queued or in flight.
        if ((state_q == S_READ || state_q == S_DRAIN) && !iRDY) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            abort_d    = 1'b1;
            pipe_vld_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, and the
    // reset is sampled on the clock edge rather than in the sensitivity list.
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            state_q    <= S_IDLE;
            rdy_q      <= 1'b1;
            cnt_q      <= '0;
            addr_q     <= '0;
            abort_q    <= 1'b0;
            pipe_vld_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i <= RD_LAT; i++) pipe_idx_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= rdy_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            abort_q    <= abort_d;
            pipe_vld_q <= pipe_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            for (int i = 0; i <= RD_LAT; i++) pipe_idx_q[i] <= pipe_idx_d[i];
        end
    end

    // NOTE: FIFO storage is deliberately not reset; an empty FIFO never
    // exposes its contents because the stream outputs are gated by valid.
    always_ff @(posedge iCLK) begin
        if (push) fifo_mem_q[wr_ptr_q] <= cap_beat;
    end

    assign strm.oVALID = (fifo_cnt_q != '0);
    assign strm.oDATA  = strm.oVALID ? head.data : '0;
    assign strm.oINDEX = strm.oVALID ? head.idx  : '0;
    assign strm.oLAST  = strm.oVALID && (head.idx == LAST_IDX);

    assign oADDR_RD_0 = addr_q;
    assign oADDR_RD_1 = addr_q;
    assign oADDR_RD_2 = addr_q;
    assign oADDR_RD_3 = addr_q;

    assign oBUSY  = (state_q == S_READ) || (state_q == S_DRAIN);
    assign oDONE  = (state_q == S_DONE);
    assign oABORT = abort_q;

endmodule

// File: tb/tb_fht_result_reader.sv
// ---------------------------------------------------------------------------
// tb_fht_result_reader
//
// Bench for fht_result_reader: four-bank RAM model with a configurable read
// latency, random consumer back-pressure, and a queue of expected beats that
// a negedge monitor pops on every handshake.
// ---------------------------------------------------------------------------
module tb_fht_result_reader;

    localparam int N       = 1024;
    localparam int D_BIT   = 16;
    localparam int A_BIT   = 8;
    localparam int RD_LAT  = 2;
    localparam int BANK_SZ = N / 4;

    logic iCLK = 1'b0;
    logic iRESET;
    logic iRDY;
    logic [A_BIT-1:0] oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3;
    logic signed [D_BIT-1:0] iDATA_0, iDATA_1, iDATA_2, iDATA_3;
    logic oBUSY, oDONE, oABORT;

    fht_result_reader_if #(.D_BIT(D_BIT), .A_BIT(A_BIT)) strm ();

    fht_result_reader #(.N(N), .D_BIT(D_BIT), .A_BIT(A_BIT), .RD_LAT(RD_LAT)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iRDY(iRDY),
        .oADDR_RD_0(oADDR_RD_0), .oADDR_RD_1(oADDR_RD_1),
        .oADDR_RD_2(oADDR_RD_2), .oADDR_RD_3(oADDR_RD_3),
        .iDATA_0(iDATA_0), .iDATA_1(iDATA_1), .iDATA_2(iDATA_2), .iDATA_3(iDATA_3),
        .oBUSY(oBUSY), .oDONE(oDONE), .oABORT(oABORT),
        .strm(strm.master)
    );

    always #5 iCLK = ~iCLK;

    // ---------------- RAM model: data appears RD_LAT clocks after address
    logic [D_BIT-1:0] mem  [4][BANK_SZ];
    logic [A_BIT-1:0] adly [4][RD_LAT];
    logic [A_BIT-1:0] addr_in [4];

    assign addr_in[0] = oADDR_RD_0;
    assign addr_in[1] = oADDR_RD_1;
    assign addr_in[2] = oADDR_RD_2;
    assign addr_in[3] = oADDR_RD_3;

    always @(posedge iCLK) begin
        for (int b = 0; b < 4; b++) begin
            adly[b][0] <= addr_in[b];
            for (int k = 1; k < RD_LAT; k++) adly[b][k] <= adly[b][k-1];
        end
    end

    assign iDATA_0 = mem[0][adly[0][RD_LAT-1]];
    assign iDATA_1 = mem[1][adly[1][RD_LAT-1]];
    assign iDATA_2 = mem[2][adly[2][RD_LAT-1]];
    assign iDATA_3 = mem[3][adly[3][RD_LAT-1]];

    // ---------------- reference model and scoreboard
    typedef struct {
        int               idx;
        logic [D_BIT-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;
    int   done_pulses = 0;
    int   abort_pulses = 0;
    int   last_beats = 0;
    logic [D_BIT-1:0] got [N];
    bit   rand_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Spectrum point n lives in bank n / (N/4), address n mod (N/4); the
    // build option swaps the two bank bits.
    function automatic logic [D_BIT-1:0] model(input int n);
        int b;
        int a;
        a = n % BANK_SZ;
`ifdef FHT_RD_BANK_BITREV_EN
        b = ((n / BANK_SZ) % 2) * 2 + (n / (2 * BANK_SZ));
`else
        b = n / BANK_SZ;
`endif
        return mem[b][a];
    endfunction

    task automatic push_frame();
        exp_t e;
        for (int n = 0; n < N; n++) begin
            e.idx  = n;
            e.data = model(n);
            exp_q.push_back(e);
        end
    endtask

    // ---------------- consumer ready driver
    initial begin
        strm.iREADY = 1'b1;
        forever begin
            @(posedge iCLK);
            #1;
            strm.iREADY = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- monitor
    initial begin
        bit               stall = 1'b0;
        logic [D_BIT-1:0] p_data = '0;
        logic [A_BIT+1:0] p_idx = '0;
        logic             p_last = 1'b0;
        exp_t             e;
        forever begin
            @(negedge iCLK);
            if (!iRESET) begin
                stall = 1'b0;
            end else begin
                if (oDONE)  done_pulses++;
                if (oABORT) abort_pulses++;
                if (dut.fifo_cnt_q > 4) check("fifo_bound", 32'(dut.fifo_cnt_q), 32'd4);
                if (stall && strm.oVALID) begin
                    check("stall_data",  32'($unsigned(strm.oDATA)), 32'(p_data));
                    check("stall_index", 32'(strm.oINDEX), 32'(p_idx));
                    check("stall_last",  32'(strm.oLAST), 32'(p_last));
                end
                if (strm.oVALID && strm.iREADY) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 32'(strm.oINDEX), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_index", 32'(strm.oINDEX), 32'(e.idx));
                        check("beat_data",  32'($unsigned(strm.oDATA)), 32'(e.data));
                        check("beat_last",  32'(strm.oLAST), 32'(e.idx == N - 1));
                        got[e.idx] = strm.oDATA;
                    end
                    if (strm.oLAST) last_beats++;
                    hs_cnt++;
                end
                stall  = strm.oVALID && !strm.iREADY;
                p_data = strm.oDATA;
                p_idx  = strm.oINDEX;
                p_last = strm.oLAST;
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic start_frame();
        iRDY = 1'b0;
        tick();
        hs_cnt      = 0;
        done_pulses = 0;
        last_beats  = 0;
        push_frame();
        iRDY = 1'b1;
    endtask

    task automatic wait_done(input int max_cycles, output int cycles);
        cycles = 0;
        while (cycles < max_cycles && !oDONE) begin
            tick();
            cycles++;
        end
        if (!oDONE) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_beats(input int n);
        int c = 0;
        while (hs_cnt < n && c < 5000) begin
            tick();
            c++;
        end
        if (hs_cnt < n) check("beat_timeout", 32'(hs_cnt), 32'(n));
    endtask

    task automatic check_frame_end(input string tag);
        int cyc;
        wait_done(20000, cyc);
        tick();
        check({tag, "_done_width"}, 32'(oDONE), 32'd0);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_beats"}, 32'(hs_cnt), 32'(N));
        check({tag, "_done_pulses"}, 32'(done_pulses), 32'd1);
        check({tag, "_last_beats"}, 32'(last_beats), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(strm.oVALID), 32'd0);
        check({tag, "_data"},  32'($unsigned(strm.oDATA)), 32'd0);
        check({tag, "_index"}, 32'(strm.oINDEX), 32'd0);
        check({tag, "_last"},  32'(strm.oLAST), 32'd0);
        check({tag, "_busy"},  32'(oBUSY), 32'd0);
        check({tag, "_done"},  32'(oDONE), 32'd0);
        check({tag, "_abort"}, 32'(oABORT), 32'd0);
        check({tag, "_addr"},  32'({oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3}), 32'd0);
    endtask

    // ---------------- main sequence
    initial begin
        int lat;
        int cyc;
        bit seen;

        for (int b = 0; b < 4; b++)
            for (int a = 0; a < BANK_SZ; a++)
                mem[b][a] = D_BIT'(b * BANK_SZ + a);

        iRESET = 1'b0;
        iRDY   = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        iRESET = 1'b1;
        tick();

        // Frame 1: consumer always ready, exact latency and frame length.
        rand_mode = 1'b0;
        start_frame();
        lat = 0;
        while (!strm.oVALID && lat < 20) begin
            tick();
            lat++;
        end
        check("first_valid_latency", 32'(lat - 1), 32'(RD_LAT + 2));
        wait_done(20000, cyc);
        check("frame_clocks", 32'(lat + cyc - 1), 32'(N + RD_LAT + 2));
        check_frame_end("full");
`ifdef FHT_RD_BANK_BITREV_EN
        check("bitrev_256", 32'(got[256]), 32'd512);
        check("bitrev_512", 32'(got[512]), 32'd256);
`else
        check("natural_256", 32'(got[256]), 32'd256);
        check("natural_512", 32'(got[512]), 32'd512);
`endif

        // Frame 2: random back-pressure.
        rand_mode = 1'b1;
        start_frame();
        check_frame_end("random");

        // Abort after 300 handshakes, then a clean restart.
        abort_pulses = 0;
        start_frame();
        wait_beats(300);
        iRDY = 1'b0;
        tick();
        exp_q.delete();
        check("abort_pulse", 32'(oABORT), 32'd1);
        check("abort_valid", 32'(strm.oVALID), 32'd0);
        check("abort_busy",  32'(oBUSY), 32'd0);
        tick();
        check("abort_width", 32'(oABORT), 32'd0);
        check("abort_count", 32'(abort_pulses), 32'd1);
        start_frame();
        check_frame_end("restart");

        // Reset mid-frame with iRDY held high through release.
        start_frame();
        wait_beats(500);
        iRESET = 1'b0;
        tick();
        exp_q.delete();
        check_all_zero("midreset");
        iRESET = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (oBUSY || strm.oVALID) seen = 1'b1;
        end
        check("no_readout_after_reset", 32'(seen), 32'd0);
        start_frame();
        check_frame_end("post_reset");

        // Sign preservation on the last point.
        mem[3][BANK_SZ-1] = '1;
        rand_mode = 1'b0;
        start_frame();
        check_frame_end("sign");
        check("sign_last_data", 32'(got[N-1]), 32'h0000_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
